fetch_pc_sequencer: RTL

Next-generation program-counter generator for the RV32I frontend. It issues fetch-block addresses to the I-cache over a valid/ready handshake, FETCH_WIDTH instructions per block, with a bounded number of requests in flight. Redirects come from the backend flush and from the predictor. An epoch tag marks responses that belong to squashed requests. It sits between the branch predictor/BPU and the I-cache, and drives the fetch queue keep/discard decision.

---
 rtl/fetch_pc_sequencer_if.sv | 30 +++
 rtl/fetch_pc_sequencer.sv | 144 ++++++++++++++
 2 files changed

// File: rtl/fetch_pc_sequencer_if.sv
// fetch_pc_sequencer_if
//   Request/response bundle between the fetch PC sequencer and the I-cache.
//   master : PC sequencer side. It drives the request and the keep decision.
//   slave  : I-cache / fetch-queue side.
//   Signals:
//     fetch_req_valid/ready/pc/epoch  request handshake carrying PC and epoch
//     fetch_rsp_valid/epoch           response for the oldest outstanding request
//     fetch_rsp_keep                  response is current; forward to decode
interface fetch_pc_sequencer_if #(
    parameter int ADDR_WIDTH  = 32,
    parameter int EPOCH_WIDTH = 2
) ();
    logic                   fetch_req_valid;
    logic                   fetch_req_ready;
    logic [ADDR_WIDTH-1:0]  fetch_req_pc;
    logic [EPOCH_WIDTH-1:0] fetch_req_epoch;
    logic                   fetch_rsp_valid;
    logic [EPOCH_WIDTH-1:0] fetch_rsp_epoch;
    logic                   fetch_rsp_keep;

    modport master (
        output fetch_req_valid, fetch_req_pc, fetch_req_epoch, fetch_rsp_keep,
        input  fetch_req_ready, fetch_rsp_valid, fetch_rsp_epoch
    );

    modport slave (
        input  fetch_req_valid, fetch_req_pc, fetch_req_epoch, fetch_rsp_keep,
        output fetch_req_ready, fetch_rsp_valid, fetch_rsp_epoch
    );
endinterface

// File: rtl/fetch_pc_sequencer.sv
// fetch_pc_sequencer
//   Program-counter generator for the RV32I frontend. Issues fetch-block
//   addresses (FETCH_WIDTH instructions per block) to the I-cache, limits the
//   number of requests in flight, and applies redirects from the backend
//   (bpu_flush) and from the predictor (bp_taken on a kept response). Each
//   redirect bumps an epoch tag so responses to squashed requests are dropped.
//
//   Ports:
//     CLK, RST            clock, asynchronous active-high reset
//     BOOT_ADDR           PC loaded at reset
//     fetch_stall         decode queue full; blocks new requests only
//     fif (master)        I-cache request/response bundle
//     bp_taken/bp_target  predictor redirect, qualified by a kept response
//     bpu_flush/target    backend redirect, highest priority
//     outstanding         requests accepted but not yet answered
//
//   Optional build macro REDIRECT_COUNTER_EN adds flush_count and
//   bp_redirect_count, free-running 32-bit counts of applied redirects.
module fetch_pc_sequencer #(
    parameter int ADDR_WIDTH      = 32,
    parameter int FETCH_WIDTH     = 2,
    parameter int MAX_OUTSTANDING = 4,
    parameter int EPOCH_WIDTH     = 2
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic [ADDR_WIDTH-1:0] BOOT_ADDR,
    input  logic                  fetch_stall,
    fetch_pc_sequencer_if.master  fif,
    input  logic                  bp_taken,
    input  logic [ADDR_WIDTH-1:0] bp_target,
    input  logic                  bpu_flush,
    input  logic [ADDR_WIDTH-1:0] bpu_target,
    output logic [3:0]            outstanding
`ifdef REDIRECT_COUNTER_EN
    ,
    output logic [31:0]           flush_count,
    output logic [31:0]           bp_redirect_count
`endif
);

    localparam logic [ADDR_WIDTH-1:0] FETCH_BYTES = ADDR_WIDTH'(4 * FETCH_WIDTH);
    localparam logic [ADDR_WIDTH-1:0] BLOCK_MASK  = ~(FETCH_BYTES - ADDR_WIDTH'(1));

    typedef enum logic [1:0] {S_BOOT, S_RUN, S_HOLD} state_t;

    state_t                 state_q, state_d;
    logic [ADDR_WIDTH-1:0]  pc_q;
    logic [EPOCH_WIDTH-1:0] epoch_q;
    logic                   req_valid;
    logic                   full;
    logic                   keep;
    logic                   hs;
    logic                   rsp_dec;
    logic                   do_flush;
    logic                   do_bp;
    logic [ADDR_WIDTH-1:0]  seq_pc;

    assign full = (outstanding >= 4'(MAX_OUTSTANDING));

    // Next-state / request-valid logic
    always_comb begin
        state_d   = state_q;
        req_valid = 1'b0;
        case (state_q)
            S_BOOT: state_d = S_RUN;
            S_RUN: begin
                req_valid = !fetch_stall && !full;
                if (fetch_stall || full) state_d = S_HOLD;
            end
            S_HOLD: begin
                if (!fetch_stall && !full) state_d = S_RUN;
            end
            default: state_d = S_BOOT;
        endcase
    end

    assign keep   = fif.fetch_rsp_valid && (fif.fetch_rsp_epoch == epoch_q);
    assign hs     = req_valid && fif.fetch_req_ready;
    // Responses with nothing in flight are protocol errors; do not underflow.
    assign rsp_dec = fif.fetch_rsp_valid && (outstanding != 4'd0);

    // BOOT lasts exactly one cycle, so a flush seen there is captured on the
    // edge into RUN, which is where it must take effect. Predictor redirects
    // are not honoured in BOOT; a flush always overrides them.
    assign do_flush = bpu_flush;
    assign do_bp    = bp_taken && keep && !bpu_flush && (state_q != S_BOOT);

    // Redirect targets may be unaligned; the next block starts at the
    // following aligned boundary and wraps at 2^ADDR_WIDTH.
    assign seq_pc = (pc_q & BLOCK_MASK) + FETCH_BYTES;

    assign fif.fetch_req_valid = req_valid;
    assign fif.fetch_req_pc    = pc_q;
    assign fif.fetch_req_epoch = epoch_q;
    assign fif.fetch_rsp_keep  = keep;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q <= S_BOOT;
            pc_q    <= BOOT_ADDR;
            epoch_q <= '0;
        end else begin
            state_q <= state_d;
            // A redirect in the same cycle as a handshake wins the PC; the
            // accepted request keeps the old epoch and will come back stale.
            if (do_flush) begin
                pc_q    <= bpu_target;
                epoch_q <= epoch_q + EPOCH_WIDTH'(1);
            end else if (do_bp) begin
                pc_q    <= bp_target;
                epoch_q <= epoch_q + EPOCH_WIDTH'(1);
            end else if (hs) begin
                pc_q    <= seq_pc;
            end
        end
    end

    // Flushes do not clear the counter; stale responses still drain it.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            outstanding <= 4'd0;
        end else begin
            case ({hs, rsp_dec})
                2'b10:   outstanding <= outstanding + 4'd1;
                2'b01:   outstanding <= outstanding - 4'd1;
                default: outstanding <= outstanding;
            endcase
        end
    end

`ifdef REDIRECT_COUNTER_EN
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            flush_count       <= 32'd0;
            bp_redirect_count <= 32'd0;
        end else begin
            if (do_flush) flush_count       <= flush_count + 32'd1;
            if (do_bp)    bp_redirect_count <= bp_redirect_count + 32'd1;
        end
    end
`endif

endmodule
